dmem_arbiter: RTL and testbench

- Shares one data-memory port between NUM_HARTS harts in the three-core system.
- Each hart issues load/store requests with a valid/ready handshake. The arbiter grants one hart at a time using round-robin priority and registers the request toward memory.
- The memory port has variable latency. The arbiter waits for the response and routes it back to the owning hart.
- One transaction is outstanding at a time.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 29 ++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin picker.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int          DEF_NUM_HARTS   = 3;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_valid_o
);

  always_comb begin
    int k;
    k           = 0;
    grant_o     = '0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!any_valid_o && req_i[k]) begin
        any_valid_o = 1'b1;
        grant_o[k]  = 1'b1;
        idx_o       = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one variable-latency data-memory port between harts,
// one transaction outstanding at a time.
//
// state | meaning
// IDLE  | arbitrate; accept one hart request, latch it
// ISSUE | present registered request to memory until i_mem_ready
// WAIT  | wait for i_mem_rvalid, capture read data
// RESP  | one-cycle response pulse to the owning hart, advance rr pointer
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_HARTS = DEF_NUM_HARTS,
  parameter int IDX_W     = $clog2(NUM_HARTS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_HARTS-1:0]   i_req_valid,
  input  logic [NUM_HARTS*32-1:0] i_req_addr,
  input  logic [NUM_HARTS-1:0]   i_req_ren,
  input  logic [NUM_HARTS-1:0]   i_req_wen,
  input  logic [NUM_HARTS*32-1:0] i_req_wdata,
  input  logic [NUM_HARTS*4-1:0] i_req_mask,
  output logic [NUM_HARTS-1:0]   o_req_ready,
  output logic [NUM_HARTS-1:0]   o_resp_valid,
  output logic [31:0]            o_resp_rdata,
  output logic                   o_resp_err,
  output logic                   o_mem_valid,
  input  logic                   i_mem_ready,
  output logic [31:0]            o_mem_addr,
  output logic                   o_mem_ren,
  output logic                   o_mem_wen,
  output logic [31:0]            o_mem_wdata,
  output logic [3:0]             o_mem_mask,
  input  logic                   i_mem_rvalid,
  input  logic [31:0]            i_mem_rdata
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;
  logic             err_q, err_d;

  logic [NUM_HARTS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic [31:0] h_addr  [NUM_HARTS];
  logic [31:0] h_wdata [NUM_HARTS];
  logic [3:0]  h_mask  [NUM_HARTS];

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_unpack
    assign h_addr[h]  = i_req_addr[32*h +: 32];
    assign h_wdata[h] = i_req_wdata[32*h +: 32];
    assign h_mask[h]  = i_req_mask[4*h +: 4];
  end

  rr_pick #(
    .N     (NUM_HARTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i       (i_req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (pick_gnt),
    .idx_o       (pick_idx),
    .any_valid_o (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mask_d   = mask_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          addr_d  = h_addr[pick_idx] & ADDR_ALIGN_MASK;
          wdata_d = h_wdata[pick_idx];
          mask_d  = h_mask[pick_idx];
          ren_d   = i_req_ren[pick_idx];
          wen_d   = i_req_wen[pick_idx];
          rdata_d = '0;
          // Both or neither enable set is answered locally without touching memory.
          err_d   = (i_req_ren[pick_idx] == i_req_wen[pick_idx]);
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          rdata_d = ren_q ? i_mem_rdata : '0;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (gnt_q == IDX_W'(NUM_HARTS - 1)) ? '0 : gnt_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mask_q   <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mask_q   <= mask_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
    end
  end

  logic in_issue, in_resp;
  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  // Ready is gated by reset so a hart holding valid sees nothing while reset is low.
  assign o_req_ready  = (i_rst_n && state_q == IDLE) ? pick_gnt : '0;

  assign o_mem_valid  = in_issue;
  assign o_mem_addr   = in_issue ? addr_q  : '0;
  assign o_mem_ren    = in_issue & ren_q;
  assign o_mem_wen    = in_issue & wen_q;
  assign o_mem_wdata  = in_issue ? wdata_q : '0;
  assign o_mem_mask   = in_issue ? mask_q  : '0;

  assign o_resp_valid = in_resp ? (NUM_HARTS'(1) << gnt_q) : '0;
  assign o_resp_rdata = in_resp ? rdata_q : '0;
  assign o_resp_err   = in_resp & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors, multi-cycle sequences and a randomized
// transaction-level reference model of harts and memory.
module tb_dmem_arbiter;

  localparam int N = 3;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    i_req_valid, i_req_ren, i_req_wen;
  logic [N*32-1:0] i_req_addr, i_req_wdata;
  logic [N*4-1:0]  i_req_mask;
  logic [N-1:0]    o_req_ready, o_resp_valid;
  logic [31:0]     o_resp_rdata;
  logic            o_resp_err;
  logic            o_mem_valid, i_mem_ready;
  logic [31:0]     o_mem_addr;
  logic            o_mem_ren, o_mem_wen;
  logic [31:0]     o_mem_wdata;
  logic [3:0]      o_mem_mask;
  logic            i_mem_rvalid;
  logic [31:0]     i_mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  dmem_arbiter #(.NUM_HARTS(N)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_ren    (i_req_ren),
    .i_req_wen    (i_req_wen),
    .i_req_wdata  (i_req_wdata),
    .i_req_mask   (i_req_mask),
    .o_req_ready  (o_req_ready),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_ren    (o_mem_ren),
    .o_mem_wen    (o_mem_wen),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  // Hart-side request state, packed onto the DUT ports by drive().
  bit          pend   [N];
  bit          waitr  [N];
  logic        r_ren  [N];
  logic        r_wen  [N];
  logic [31:0] r_addr [N];
  logic [31:0] r_wdata[N];
  logic [3:0]  r_mask [N];
  int          budget [N];
  int          gap    [N];
  int          grants [$];

  typedef struct {
    int          hart;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] mrdata;
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  task automatic drive();
    for (int h = 0; h < N; h++) begin
      i_req_valid[h]         = pend[h];
      i_req_ren[h]           = r_ren[h];
      i_req_wen[h]           = r_wen[h];
      i_req_addr[h*32 +: 32] = r_addr[h];
      i_req_wdata[h*32 +: 32] = r_wdata[h];
      i_req_mask[h*4 +: 4]   = r_mask[h];
    end
  endtask

  task automatic set_req(input int h, input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
    pend[h]    = 1'b1;
    r_ren[h]   = ren;
    r_wen[h]   = wen;
    r_addr[h]  = addr;
    r_wdata[h] = wdata;
    r_mask[h]  = mask;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    for (int h = 0; h < N; h++) pend[h] = 1'b0;
    drive();
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic new_req(input int h);
    int r;
    r = $urandom_range(0, 9);
    set_req(h, (r == 0) || (r >= 2 && r <= 5), (r == 0) || (r >= 6),
            $urandom(), $urandom(), 4'($urandom_range(0, 15)));
  endtask

  // Transaction-level model: harts issue requests, the arbiter must grant the first
  // pending hart at or after (last owner + 1) whenever it has nothing outstanding.
  task automatic engine(input int b0, input int b1, input int b2, input int gapmax, input int maxcyc);
    bit          busy, mem_exp, mem_out, resp_now, nxt_resp;
    int          mem_cnt, owner, rr, win, cyc_n;
    int          others[N];
    logic [N-1:0] exp_rdy;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_mask;
    logic        e_ren, e_wen, e_err;
    busy = 0; mem_exp = 0; mem_out = 0; resp_now = 0;
    mem_cnt = 0; owner = 0; rr = 0; cyc_n = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_mask = '0; e_ren = 0; e_wen = 0; e_err = 0;
    budget[0] = b0; budget[1] = b1; budget[2] = b2;
    for (int h = 0; h < N; h++) begin
      gap[h] = 0; waitr[h] = 0; pend[h] = 0; others[h] = 0;
    end
    grants.delete();
    while (cyc_n < maxcyc) begin
      if (budget[0] == 0 && budget[1] == 0 && budget[2] == 0 && !busy &&
          !pend[0] && !pend[1] && !pend[2]) break;
      cyc();
      for (int h = 0; h < N; h++) begin
        if (!pend[h] && !waitr[h] && budget[h] > 0) begin
          if (gap[h] > 0) gap[h]--;
          else begin
            new_req(h);
            budget[h]--;
          end
        end
      end
      drive();
      i_mem_ready = ($urandom_range(0, 3) != 0);
      if (mem_out) begin
        i_mem_rvalid = (mem_cnt == 0);
        if (mem_cnt > 0) mem_cnt--;
      end else begin
        i_mem_rvalid = ($urandom_range(0, 7) == 0);
      end
      i_mem_rdata = $urandom();
      smp();

      win = -1;
      exp_rdy = '0;
      if (!busy)
        for (int k = 0; k < N; k++)
          if (win < 0 && pend[(rr + k) % N]) win = (rr + k) % N;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("eng req_ready", 32'(o_req_ready), 32'(exp_rdy));

      chk("eng mem_valid", 32'(o_mem_valid), 32'(mem_exp));
      chk("eng mem_addr",  o_mem_addr,  mem_exp ? e_addr : 32'h0);
      chk("eng mem_ren",   32'(o_mem_ren),   32'(mem_exp & e_ren));
      chk("eng mem_wen",   32'(o_mem_wen),   32'(mem_exp & e_wen));
      chk("eng mem_wdata", o_mem_wdata, mem_exp ? e_wdata : 32'h0);
      chk("eng mem_mask",  32'(o_mem_mask),  mem_exp ? 32'(e_mask) : 32'h0);

      chk("eng resp_valid", 32'(o_resp_valid), resp_now ? (32'h1 << owner) : 32'h0);
      if (resp_now) begin
        chk("eng resp_rdata", o_resp_rdata, e_rdata);
        chk("eng resp_err",   32'(o_resp_err), 32'(e_err));
      end

      nxt_resp = 0;
      if (resp_now) begin
        busy = 0;
        waitr[owner] = 0;
        rr = (owner + 1) % N;
        gap[owner] = $urandom_range(0, gapmax);
      end
      if (mem_out && i_mem_rvalid) begin
        mem_out  = 0;
        nxt_resp = 1;
        e_rdata  = e_ren ? i_mem_rdata : 32'h0;
        e_err    = 0;
      end
      if (mem_exp && i_mem_ready) begin
        mem_exp = 0;
        mem_out = 1;
        mem_cnt = $urandom_range(0, 3);
      end
      if (win >= 0) begin
        owner = win;
        busy = 1;
        pend[win] = 0;
        waitr[win] = 1;
        grants.push_back(win);
        chk("eng fairness", 32'(others[win] < N), 32'h1);
        others[win] = 0;
        for (int h = 0; h < N; h++) if (pend[h]) others[h]++;
        e_addr  = r_addr[win] & 32'hFFFF_FFFC;
        e_wdata = r_wdata[win];
        e_mask  = r_mask[win];
        e_ren   = r_ren[win];
        e_wen   = r_wen[win];
        if (r_ren[win] == r_wen[win]) begin
          nxt_resp = 1;
          e_err    = 1;
          e_rdata  = 32'h0;
        end else begin
          mem_exp = 1;
        end
      end
      resp_now = nxt_resp;
      cyc_n++;
    end
    if (cyc_n >= maxcyc) chk("eng timeout", 32'(cyc_n), 32'(maxcyc - 1));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    cyc();
    i_mem_ready  = 1'b1;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    set_req(v.hart, v.ren, v.wen, v.addr, v.wdata, v.mask);
    drive();
    smp();
    chk($sformatf("vec%0d req_ready", idx), 32'(o_req_ready), 32'h1 << v.hart);
    cyc();
    pend[v.hart] = 1'b0;
    drive();
    smp();
    if (v.exp_err) begin
      chk($sformatf("vec%0d mem_valid", idx), 32'(o_mem_valid), 32'h0);
    end else begin
      chk($sformatf("vec%0d mem_valid", idx), 32'(o_mem_valid), 32'h1);
      chk($sformatf("vec%0d mem_addr", idx),  o_mem_addr, v.exp_addr);
      chk($sformatf("vec%0d mem_ren", idx),   32'(o_mem_ren), 32'(v.ren));
      chk($sformatf("vec%0d mem_wen", idx),   32'(o_mem_wen), 32'(v.wen));
      chk($sformatf("vec%0d mem_wdata", idx), o_mem_wdata, v.wdata);
      chk($sformatf("vec%0d mem_mask", idx),  32'(o_mem_mask), 32'(v.mask));
      for (int c = 1; c <= v.lat; c++) begin
        cyc();
        i_mem_rvalid = (c == v.lat);
        i_mem_rdata  = v.mrdata;
        smp();
        chk($sformatf("vec%0d wait mem_valid", idx), 32'(o_mem_valid), 32'h0);
        chk($sformatf("vec%0d wait resp", idx), 32'(o_resp_valid), 32'h0);
      end
      cyc();
      i_mem_rvalid = 1'b0;
      smp();
    end
    chk($sformatf("vec%0d resp_valid", idx), 32'(o_resp_valid), 32'h1 << v.hart);
    chk($sformatf("vec%0d resp_rdata", idx), o_resp_rdata, v.exp_rdata);
    chk($sformatf("vec%0d resp_err", idx),   32'(o_resp_err), 32'(v.exp_err));
    cyc();
    smp();
    chk($sformatf("vec%0d resp_done", idx), 32'(o_resp_valid), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[4];
    exp_a = '{0, 1, 2, 0};
    vecs[0] = '{1, 1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'b1100, 32'hDEAD_BEEF, 1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{2, 1'b0, 1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000, 32'h1234_5678, 1, 32'h0000_2000, 32'h0, 1'b0};
    vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_0030, 32'h0, 4'b1111, 32'h0, 1, 32'h0, 32'h0, 1'b1};
    vecs[3] = '{1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'b0001, 32'h0, 1, 32'h0, 32'h0, 1'b1};
    vecs[4] = '{2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h7777_0000, 4'b1111, 32'h0BAD_F00D, 4, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{0, 1'b0, 1'b1, 32'h0000_0004, 32'h55AA_55AA, 4'b1111, 32'hFFFF_FFFF, 3, 32'h0000_0004, 32'h0, 1'b0};

    // Reset with every hart requesting: nothing may be accepted or driven.
    i_rst_n = 1'b0;
    i_mem_ready = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    for (int h = 0; h < N; h++) set_req(h, 1'b1, 1'b0, 32'h100 * h, 32'h0, 4'hF);
    drive();
    #3;
    chk("reset req_ready", 32'(o_req_ready), 32'h0);
    chk("reset mem_valid", 32'(o_mem_valid), 32'h0);
    chk("reset mem_addr",  o_mem_addr, 32'h0);
    chk("reset resp_valid", 32'(o_resp_valid), 32'h0);
    chk("reset resp_rdata", o_resp_rdata, 32'h0);
    do_reset();

    // Three simultaneous requesters, hart0 re-requesting at once.
    engine(2, 1, 1, 0, 400);
    chk("seqA grant count", 32'(grants.size()), 32'h4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk($sformatf("seqA grant%0d", k), 32'(grants[k]), 32'(exp_a[k]));

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Backpressure: memory stalls for 5 cycles while other harts wait.
    cyc();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    drive();
    smp();
    chk("bp accept", 32'(o_req_ready), 32'h2);
    cyc();
    pend[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    set_req(2, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    drive();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      smp();
      chk("bp mem_valid", 32'(o_mem_valid), 32'h1);
      chk("bp mem_addr",  o_mem_addr, 32'h500);
      chk("bp mem_ren",   32'(o_mem_ren), 32'h1);
      chk("bp mem_mask",  32'(o_mem_mask), 32'hF);
      chk("bp no ready",  32'(o_req_ready), 32'h0);
    end
    cyc(); i_mem_ready = 1'b1; smp();
    chk("bp handshake valid", 32'(o_mem_valid), 32'h1);
    chk("bp handshake ready", 32'(o_req_ready), 32'h0);
    cyc(); i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_F00D; smp();
    chk("bp wait mem_valid", 32'(o_mem_valid), 32'h0);
    chk("bp wait resp", 32'(o_resp_valid), 32'h0);
    cyc(); i_mem_rvalid = 1'b0; smp();
    chk("bp resp_valid", 32'(o_resp_valid), 32'h2);
    chk("bp resp_rdata", o_resp_rdata, 32'hCAFE_F00D);
    chk("bp resp ready", 32'(o_req_ready), 32'h0);
    cyc(); smp();
    chk("bp rr next grant", 32'(o_req_ready), 32'h4);
    cyc(); pend[2] = 1'b0; drive(); i_mem_ready = 1'b1; smp();
    chk("bp2 mem_addr", o_mem_addr, 32'h700);
    cyc(); i_mem_ready = 1'b0; smp();
    chk("bp2 wait", 32'(o_mem_valid), 32'h0);

    // Reset during WAIT with hart0 still requesting.
    #1 i_rst_n = 1'b0;
    #1;
    chk("async rst req_ready", 32'(o_req_ready), 32'h0);
    chk("async rst mem_valid", 32'(o_mem_valid), 32'h0);
    chk("async rst resp_valid", 32'(o_resp_valid), 32'h0);
    chk("async rst resp_err", 32'(o_resp_err), 32'h0);
    for (int h = 0; h < N; h++) pend[h] = 1'b0;
    drive();
    cyc();
    i_rst_n = 1'b1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_1111;
    smp();
    chk("late rvalid resp", 32'(o_resp_valid), 32'h0);
    chk("late rvalid mem", 32'(o_mem_valid), 32'h0);
    cyc(); i_mem_rvalid = 1'b0; smp();
    chk("late rvalid resp2", 32'(o_resp_valid), 32'h0);
    cyc();
    for (int h = 0; h < N; h++) set_req(h, 1'b1, 1'b0, 32'h40 * h, 32'h0, 4'hF);
    drive();
    smp();
    chk("rst rr_ptr grant", 32'(o_req_ready), 32'h1);
    do_reset();

    engine(40, 40, 40, 4, 20000);
    chk("rand grant count", 32'(grants.size()), 32'd120);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
